// File: rtl/cp_all_fdssi_fdsti_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cp_all_pkg
// Desc     : Shared widths, stage-count helper and tie-break ordering for the
//            pipelined all-entry FDSTI/FDSSI compare tree.
// Revision : 1.0 - initial release
// ============================================================================
package cp_all_pkg;

    localparam int c_fdsti_w_default = 28;
    localparam int c_fdssi_w_default = 12;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } sel_e;

    // Lower-index side keeps the slot on a full tie and when nothing is valid,
    // which makes the root report the lowest-index optimal entry.
    localparam sel_e c_sel_tie           = SEL_A;
    localparam sel_e c_sel_both_invalid  = SEL_A;

    function automatic int cp_all_stages(input int o_sam_width, input int pipe_every);
        return (o_sam_width + pipe_every - 1) / pipe_every;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cp_all_fdssi_fdsti_pipe_sel.sv
`default_nettype none
// ============================================================================
// Module   : cp2_fdsti_fdssi_sel
// Desc     : Combinational 2-way tournament node (a = lower index side).
//            CP_ALL_IDX_EN adds an entry-index pass-through.
// Revision : 1.0 - initial release
// ============================================================================
module cp2_fdsti_fdssi_sel
    import cp_all_pkg::*;
#(
    parameter int FDSTI_W = c_fdsti_w_default,
    parameter int FDSSI_W = c_fdssi_w_default
`ifdef CP_ALL_IDX_EN
    ,
    parameter int IDX_W   = 2
`endif
)(
    input  logic               i_a_valid,
    input  logic               i_a_wt,
    input  logic [FDSTI_W-1:0] i_a_fdsti,
    input  logic [FDSSI_W-1:0] i_a_fdssi,
    input  logic               i_b_valid,
    input  logic               i_b_wt,
    input  logic [FDSTI_W-1:0] i_b_fdsti,
    input  logic [FDSSI_W-1:0] i_b_fdssi,
    output logic               o_valid,
    output logic               o_wt,
    output logic [FDSTI_W-1:0] o_fdsti,
    output logic [FDSSI_W-1:0] o_fdssi
`ifdef CP_ALL_IDX_EN
    ,
    input  logic [IDX_W-1:0]   i_a_idx,
    input  logic [IDX_W-1:0]   i_b_idx,
    output logic [IDX_W-1:0]   o_idx
`endif
);

    sel_e w_sel;

    always_comb begin
        w_sel = c_sel_tie;
        if (!i_a_valid && !i_b_valid)
            w_sel = c_sel_both_invalid;
        else if (!i_b_valid)
            w_sel = SEL_A;
        else if (!i_a_valid)
            w_sel = SEL_B;
        else if (i_a_wt != i_b_wt)
            w_sel = i_a_wt ? SEL_B : SEL_A;
        else if (i_a_fdsti != i_b_fdsti)
            w_sel = (i_b_fdsti < i_a_fdsti) ? SEL_B : SEL_A;
        else if (i_a_fdssi != i_b_fdssi)
            w_sel = (i_b_fdssi < i_a_fdssi) ? SEL_B : SEL_A;
        else
            w_sel = c_sel_tie;
    end

    assign o_valid = i_a_valid | i_b_valid;
    assign o_wt    = (w_sel == SEL_B) ? i_b_wt    : i_a_wt;
    assign o_fdsti = (w_sel == SEL_B) ? i_b_fdsti : i_a_fdsti;
    assign o_fdssi = (w_sel == SEL_B) ? i_b_fdssi : i_a_fdssi;
`ifdef CP_ALL_IDX_EN
    assign o_idx   = (w_sel == SEL_B) ? i_b_idx   : i_a_idx;
`endif

endmodule
`default_nettype wire

// File: rtl/cp_all_fdssi_fdsti_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cp_all_fdssi_fdsti_pipe
// Desc     : Pipelined tournament tree picking one winner out of
//            2**O_SAM_WIDTH candidates, valid/ready at both ends.
//            Define CP_ALL_IDX_EN to add the winner index output idx_o.
// Revision : 1.0 - initial release
// ============================================================================
module cp_all_fdssi_fdsti_pipe
    import cp_all_pkg::*;
#(
    parameter int O_SAM_WIDTH   = 2,
    parameter int I_FDSTI_WIDTH = c_fdsti_w_default,
    parameter int I_FDSSI_WIDTH = c_fdssi_w_default,
    parameter int PIPE_EVERY    = 1
)(
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [(1 << O_SAM_WIDTH)-1:0]               valid,
    input  logic [(1 << O_SAM_WIDTH)-1:0]               wt,
    input  logic [I_FDSTI_WIDTH*(1 << O_SAM_WIDTH)-1:0] FDSTI,
    input  logic [I_FDSSI_WIDTH*(1 << O_SAM_WIDTH)-1:0] FDSSI,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic                                        valid_o,
    output logic                                        wt_o,
    output logic [I_FDSTI_WIDTH-1:0]                    FDSTI_o,
    output logic [I_FDSSI_WIDTH-1:0]                    FDSSI_o
`ifdef CP_ALL_IDX_EN
    ,
    output logic [O_SAM_WIDTH-1:0]                      idx_o
`endif
);

    localparam int c_n      = 1 << O_SAM_WIDTH;
    localparam int c_stages = cp_all_stages(O_SAM_WIDTH, PIPE_EVERY);
    localparam int c_last   = O_SAM_WIDTH - 1;

    logic [c_stages-1:0] r_vld;
    logic [c_stages-1:0] w_en;

    // Unrolled form of en[s] = !vld[s] || en[s+1]: any hole downstream lets s move.
    for (genvar s = 0; s < c_stages; s++) begin : g_en
        assign w_en[s] = out_ready | ~(&r_vld[c_stages-1:s]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            if (w_en[0])
                r_vld[0] <= in_valid;
            for (int s = 1; s < c_stages; s++) begin
                if (w_en[s])
                    r_vld[s] <= r_vld[s-1];
            end
        end
    end

    assign in_ready  = w_en[0];
    assign out_valid = r_vld[c_stages-1];

    for (genvar l = 0; l < O_SAM_WIDTH; l++) begin : g_lvl
        localparam int c_m     = c_n >> l;
        localparam int c_h     = c_m / 2;
        localparam int c_stage = l / PIPE_EVERY;
        localparam bit c_reg   = ((l % PIPE_EVERY) == (PIPE_EVERY - 1)) || (l == c_last);

        logic [c_m-1:0]               w_in_v;
        logic [c_m-1:0]               w_in_wt;
        logic [c_m*I_FDSTI_WIDTH-1:0] w_in_ti;
        logic [c_m*I_FDSSI_WIDTH-1:0] w_in_si;
        logic [c_h-1:0]               w_out_v;
        logic [c_h-1:0]               w_out_wt;
        logic [c_h*I_FDSTI_WIDTH-1:0] w_out_ti;
        logic [c_h*I_FDSSI_WIDTH-1:0] w_out_si;
        logic [c_h-1:0]               w_q_v;
        logic [c_h-1:0]               w_q_wt;
        logic [c_h*I_FDSTI_WIDTH-1:0] w_q_ti;
        logic [c_h*I_FDSSI_WIDTH-1:0] w_q_si;
`ifdef CP_ALL_IDX_EN
        logic [c_m*O_SAM_WIDTH-1:0]   w_in_idx;
        logic [c_h*O_SAM_WIDTH-1:0]   w_out_idx;
        logic [c_h*O_SAM_WIDTH-1:0]   w_q_idx;
`endif

        if (l == 0) begin : g_src_ports
            assign w_in_v  = valid;
            assign w_in_wt = wt;
            assign w_in_ti = FDSTI;
            assign w_in_si = FDSSI;
`ifdef CP_ALL_IDX_EN
            for (genvar k = 0; k < c_n; k++) begin : g_idx
                assign w_in_idx[k*O_SAM_WIDTH +: O_SAM_WIDTH] = O_SAM_WIDTH'(k);
            end
`endif
        end else begin : g_src_prev
            assign w_in_v  = g_lvl[l-1].w_q_v;
            assign w_in_wt = g_lvl[l-1].w_q_wt;
            assign w_in_ti = g_lvl[l-1].w_q_ti;
            assign w_in_si = g_lvl[l-1].w_q_si;
`ifdef CP_ALL_IDX_EN
            assign w_in_idx = g_lvl[l-1].w_q_idx;
`endif
        end

        for (genvar j = 0; j < c_h; j++) begin : g_node
            cp2_fdsti_fdssi_sel #(
                .FDSTI_W (I_FDSTI_WIDTH),
                .FDSSI_W (I_FDSSI_WIDTH)
`ifdef CP_ALL_IDX_EN
                ,
                .IDX_W   (O_SAM_WIDTH)
`endif
            ) u_node (
                .i_a_valid (w_in_v[2*j]),
                .i_a_wt    (w_in_wt[2*j]),
                .i_a_fdsti (w_in_ti[(2*j)*I_FDSTI_WIDTH +: I_FDSTI_WIDTH]),
                .i_a_fdssi (w_in_si[(2*j)*I_FDSSI_WIDTH +: I_FDSSI_WIDTH]),
                .i_b_valid (w_in_v[2*j+1]),
                .i_b_wt    (w_in_wt[2*j+1]),
                .i_b_fdsti (w_in_ti[(2*j+1)*I_FDSTI_WIDTH +: I_FDSTI_WIDTH]),
                .i_b_fdssi (w_in_si[(2*j+1)*I_FDSSI_WIDTH +: I_FDSSI_WIDTH]),
                .o_valid   (w_out_v[j]),
                .o_wt      (w_out_wt[j]),
                .o_fdsti   (w_out_ti[j*I_FDSTI_WIDTH +: I_FDSTI_WIDTH]),
                .o_fdssi   (w_out_si[j*I_FDSSI_WIDTH +: I_FDSSI_WIDTH])
`ifdef CP_ALL_IDX_EN
                ,
                .i_a_idx   (w_in_idx[(2*j)*O_SAM_WIDTH +: O_SAM_WIDTH]),
                .i_b_idx   (w_in_idx[(2*j+1)*O_SAM_WIDTH +: O_SAM_WIDTH]),
                .o_idx     (w_out_idx[j*O_SAM_WIDTH +: O_SAM_WIDTH])
`endif
            );
        end

        // Data registers carry no reset; the occupancy bits qualify them.
        if (c_reg) begin : g_reg
            logic [c_h-1:0]               r_v;
            logic [c_h-1:0]               r_wt;
            logic [c_h*I_FDSTI_WIDTH-1:0] r_ti;
            logic [c_h*I_FDSSI_WIDTH-1:0] r_si;
`ifdef CP_ALL_IDX_EN
            logic [c_h*O_SAM_WIDTH-1:0]   r_idx;
`endif
            always_ff @(posedge clk) begin
                if (w_en[c_stage]) begin
                    r_v  <= w_out_v;
                    r_wt <= w_out_wt;
                    r_ti <= w_out_ti;
                    r_si <= w_out_si;
`ifdef CP_ALL_IDX_EN
                    r_idx <= w_out_idx;
`endif
                end
            end
            assign w_q_v  = r_v;
            assign w_q_wt = r_wt;
            assign w_q_ti = r_ti;
            assign w_q_si = r_si;
`ifdef CP_ALL_IDX_EN
            assign w_q_idx = r_idx;
`endif
        end else begin : g_comb
            assign w_q_v  = w_out_v;
            assign w_q_wt = w_out_wt;
            assign w_q_ti = w_out_ti;
            assign w_q_si = w_out_si;
`ifdef CP_ALL_IDX_EN
            assign w_q_idx = w_out_idx;
`endif
        end
    end

    assign valid_o = out_valid & g_lvl[c_last].w_q_v[0];
    assign wt_o    = out_valid & g_lvl[c_last].w_q_wt[0];
    assign FDSTI_o = out_valid ? g_lvl[c_last].w_q_ti : '0;
    assign FDSSI_o = out_valid ? g_lvl[c_last].w_q_si : '0;
`ifdef CP_ALL_IDX_EN
    assign idx_o   = valid_o ? g_lvl[c_last].w_q_idx : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cp_all_fdssi_fdsti_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp_all_fdssi_fdsti_pipe
// Desc     : Scoreboard bench for the pipelined FDSTI/FDSSI compare tree.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cp_all_fdssi_fdsti_pipe;

    localparam int c_o  = 2;
    localparam int c_n  = 1 << c_o;
    localparam int c_fw = 28;
    localparam int c_sw = 12;
    localparam int c_pe = 1;
    localparam int c_s  = (c_o + c_pe - 1) / c_pe;
    localparam int c_rw = 4 + c_fw + c_sw + c_o;

    typedef struct {
        logic [c_n-1:0]      v;
        logic [c_n-1:0]      wt;
        logic [c_n*c_fw-1:0] ti;
        logic [c_n*c_sw-1:0] si;
    } vec_t;

    typedef struct {
        logic            v;
        logic            wt;
        logic [c_fw-1:0] ti;
        logic [c_sw-1:0] si;
        int              idx;
    } res_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [c_n-1:0]      valid = '0;
    logic [c_n-1:0]      wt = '0;
    logic [c_n*c_fw-1:0] FDSTI = '0;
    logic [c_n*c_sw-1:0] FDSSI = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic                valid_o;
    logic                wt_o;
    logic [c_fw-1:0]     FDSTI_o;
    logic [c_sw-1:0]     FDSSI_o;
    logic [c_o-1:0]      idx_obs;

    int   total = 0;
    int   bad = 0;
    int   rdy_mode = 0;
    logic rdy_hold = 1'b1;
    bit   saw_busy = 1'b0;
    res_t exp_q[$];

    always #5 clk = ~clk;

    cp_all_fdssi_fdsti_pipe #(
        .O_SAM_WIDTH   (c_o),
        .I_FDSTI_WIDTH (c_fw),
        .I_FDSSI_WIDTH (c_sw),
        .PIPE_EVERY    (c_pe)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .valid     (valid),
        .wt        (wt),
        .FDSTI     (FDSTI),
        .FDSSI     (FDSSI),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .valid_o   (valid_o),
        .wt_o      (wt_o),
        .FDSTI_o   (FDSTI_o),
        .FDSSI_o   (FDSSI_o)
`ifdef CP_ALL_IDX_EN
        ,
        .idx_o     (idx_obs)
`endif
    );

`ifndef CP_ALL_IDX_EN
    assign idx_obs = '0;
`endif

    // Reference: lexicographic key {wt, FDSTI, FDSSI} over valid entries,
    // strict less-than scan so the lowest index wins among equals.
    function automatic res_t model(input vec_t x);
        res_t r;
        int best = -1;
        logic [c_fw+c_sw:0] key;
        logic [c_fw+c_sw:0] bkey = '0;
        for (int k = 0; k < c_n; k++) begin
            if (x.v[k]) begin
                key = {x.wt[k], x.ti[k*c_fw +: c_fw], x.si[k*c_sw +: c_sw]};
                if (best < 0 || key < bkey) begin
                    best = k;
                    bkey = key;
                end
            end
        end
        if (best < 0) begin
            r.v = 1'b0; r.wt = x.wt[0]; r.ti = x.ti[c_fw-1:0]; r.si = x.si[c_sw-1:0]; r.idx = 0;
        end else begin
            r.v = 1'b1; r.wt = x.wt[best]; r.ti = x.ti[best*c_fw +: c_fw];
            r.si = x.si[best*c_sw +: c_sw]; r.idx = best;
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic [c_n-1:0] v, input logic [c_n-1:0] w,
                                input int t3, input int t2, input int t1, input int t0,
                                input int s3, input int s2, input int s1, input int s0);
        vec_t x;
        x.v  = v;
        x.wt = w;
        x.ti = {c_fw'(t3), c_fw'(t2), c_fw'(t1), c_fw'(t0)};
        x.si = {c_sw'(s3), c_sw'(s2), c_sw'(s1), c_sw'(s0)};
        return x;
    endfunction

    function automatic res_t mkres(input logic v, input logic w, input int t, input int s, input int i);
        res_t r;
        r.v = v; r.wt = w; r.ti = c_fw'(t); r.si = c_sw'(s); r.idx = i;
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t x;
        for (int k = 0; k < c_n; k++) begin
            x.v[k]  = ($urandom % 4) != 0;
            x.wt[k] = ($urandom % 4) == 0;
            x.ti[k*c_fw +: c_fw] = ($urandom % 2) ? c_fw'($urandom_range(0, 3)) : c_fw'($urandom);
            x.si[k*c_sw +: c_sw] = ($urandom % 2) ? c_sw'($urandom_range(0, 3)) : c_sw'($urandom);
        end
        if ($urandom % 10 == 0)
            x.v = '0;
        return x;
    endfunction

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input vec_t x, input res_t e);
        int waitc = 0;
        valid = x.v; wt = x.wt; FDSTI = x.ti; FDSSI = x.si;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                break;
            end
            saw_busy = 1'b1;
            waitc++;
            if (waitc > 200) begin
                total++; bad++;
                $display("FAIL in_ready_timeout got=0 want=1");
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int c = 0;
        rdy_mode = 0;
        rdy_hold = 1'b1;
        while (exp_q.size() != 0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d want=0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_state(input string name);
        logic [c_rw-1:0] got;
        @(negedge clk);
        got = {out_valid, valid_o, wt_o, FDSTI_o, FDSSI_o, idx_obs, in_ready};
        total++;
        if (got !== c_rw'(1)) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, c_rw'(1));
        end
    endtask

    initial begin : p_rdy
        int pc = 0;
        forever begin
            @(posedge clk); #2;
            case (rdy_mode)
                0:       out_ready = rdy_hold;
                1: begin out_ready = ((pc % 4) == 0) || ((pc % 4) == 3); pc++; end
                default: out_ready = ($urandom % 4) != 0;
            endcase
        end
    end

    initial begin : p_mon
        bit              held = 1'b0;
        logic [c_rw-2:0] snap = '0;
        logic [c_rw-2:0] cur;
        res_t            e;
        int              want_idx;
        forever begin
            @(negedge clk);
            cur = {out_valid, valid_o, wt_o, FDSTI_o, FDSSI_o, idx_obs};
            if (rst) begin
                held = 1'b0;
                continue;
            end
            if (held) begin
                total++;
                if (cur !== snap) begin
                    bad++;
                    $display("FAIL stall_hold got=%h want=%h", cur, snap);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_result got v=%0b ti=%0d si=%0d want=none", valid_o, FDSTI_o, FDSSI_o);
                end else begin
                    e = exp_q.pop_front();
`ifdef CP_ALL_IDX_EN
                    want_idx = e.idx;
`else
                    want_idx = 0;
`endif
                    if (valid_o !== e.v || wt_o !== e.wt || FDSTI_o !== e.ti || FDSSI_o !== e.si ||
                        int'(idx_obs) != want_idx) begin
                        bad++;
                        $display("FAIL result got v=%0b wt=%0b ti=%0d si=%0d idx=%0d want v=%0b wt=%0b ti=%0d si=%0d idx=%0d",
                                 valid_o, wt_o, FDSTI_o, FDSSI_o, idx_obs, e.v, e.wt, e.ti, e.si, want_idx);
                    end
                end
            end
            held = out_valid && !out_ready;
            snap = cur;
        end
    end

    initial begin : p_watchdog
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin : p_main
        vec_t x;
        int   c;
        rst = 1'b1;
        rdy_mode = 0;
        rdy_hold = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_state("reset_state");
        @(posedge clk); #1;

        // Directed cases with hand-computed winners
        send(mk(4'b1111, 4'b0000, 40, 10, 30, 20, 0, 0, 0, 0), mkres(1'b1, 1'b0, 10, 0, 2));
        c = 0;
        while (c < 10) begin
            @(negedge clk);
            c++;
            if (out_valid) break;
        end
        total++;
        if (c != c_s) begin
            bad++;
            $display("FAIL latency got=%0d want=%0d", c, c_s);
        end
        @(posedge clk); #1;
        send(mk(4'b1111, 4'b0000, 5, 5, 5, 5, 7, 3, 3, 9), mkres(1'b1, 1'b0, 5, 3, 1));
        send(mk(4'b1010, 4'b0010, 50, 0, 1, 0, 4, 0, 0, 0), mkres(1'b1, 1'b0, 50, 4, 3));
        send(mk(4'b0000, 4'b0001, 3, 3, 3, 77, 1, 1, 1, 33), mkres(1'b0, 1'b1, 77, 33, 0));
        drain();

        // Back-to-back stream under a 1,0,0,1 out_ready pattern
        saw_busy = 1'b0;
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) begin
            x = rand_vec();
            send(x, model(x));
        end
        total++;
        if (!saw_busy) begin
            bad++;
            $display("FAIL in_ready_backpressure got=never_low want=low_once");
        end
        drain();

        // Random traffic with random gaps and random out_ready
        rdy_mode = 2;
        for (int i = 0; i < 150; i++) begin
            x = rand_vec();
            send(x, model(x));
            if ($urandom % 3 == 0) begin
                @(posedge clk); #1;
            end
        end
        drain();

        // Reset with two vectors in flight
        rdy_hold = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            x = rand_vec();
            send(x, model(x));
        end
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_state("reset_midflight");
        @(posedge clk); #1;
        rdy_hold = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            x = rand_vec();
            send(x, model(x));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
